// File: rtl/mem_ctrl.sv
// CPU-side initiator for the byte-serial system memory bus: it turns word fetches
// and byte/half/word loads and stores into little-endian byte accesses.
module mem_ctrl #(
   parameter int IO_ADDR_HI = 17
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

   state_t      state;
   logic [31:0] base;
   logic [31:0] wbuf;
   logic [31:0] rbuf;
   logic [31:0] merged;
   logic [2:0]  nbytes;
   logic [2:0]  ls_n;
   logic [2:0]  issue_idx;
   logic [2:0]  next_idx;
   logic [2:0]  cap_cnt;
   logic        pend_valid;
   logic [1:0]  pend_idx;
   logic        is_fetch;
   logic        base_io;
   logic        ls_io;
   logic        last_write;
   logic        last_pend;

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

   always_comb begin
      case (ls_size)
         2'd0:    ls_n = 3'd1;
         2'd1:    ls_n = 3'd2;
         default: ls_n = 3'd4;
      endcase
   end

   always_comb begin
      merged = rbuf;
      merged[{pend_idx, 3'b000} +: 8] = mem_din;
   end

   assign base_io    = (base[IO_ADDR_HI -: 2] == 2'b11);
   assign ls_io      = (ls_addr[IO_ADDR_HI -: 2] == 2'b11);
   assign next_idx   = issue_idx + 3'd1;
   assign last_write = (next_idx == nbytes);
   assign last_pend  = ({1'b0, pend_idx} == (nbytes - 3'd1));

   // A pause (rdy_in low) drops any pending byte and rewinds issue to the lowest
   // uncaptured lane, so lanes only fill from bytes whose full address/data
   // window happened while the CPU owned the bus.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= IDLE;
         mem_a      <= '0;
         mem_wr     <= 1'b0;
         mem_dout   <= '0;
         if_done    <= 1'b0;
         ls_done    <= 1'b0;
         if_data    <= '0;
         ls_rdata   <= '0;
         base       <= '0;
         wbuf       <= '0;
         rbuf       <= '0;
         nbytes     <= '0;
         issue_idx  <= '0;
         cap_cnt    <= '0;
         pend_valid <= 1'b0;
         pend_idx   <= '0;
         is_fetch   <= 1'b0;
      end else begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         case (state)
            IDLE: begin
               mem_a      <= '0;
               mem_wr     <= 1'b0;
               issue_idx  <= '0;
               cap_cnt    <= '0;
               pend_valid <= 1'b0;
               rbuf       <= '0;
               if (rdy_in && ls_req && !ls_done) begin
                  base     <= ls_addr;
                  wbuf     <= ls_wdata;
                  nbytes   <= ls_n;
                  is_fetch <= 1'b0;
                  if (!ls_we) begin
                     state <= READ;
                     mem_a <= ls_addr;
                  end else if (ls_io && io_buffer_full) begin
                     state <= IO_WAIT;
                  end else begin
                     state    <= WRITE;
                     mem_wr   <= 1'b1;
                     mem_a    <= ls_addr;
                     mem_dout <= ls_wdata[7:0];
                  end
               end else if (rdy_in && if_req && !if_done) begin
                  base     <= if_addr;
                  nbytes   <= 3'd4;
                  is_fetch <= 1'b1;
                  state    <= READ;
                  mem_a    <= if_addr;
               end
            end

            READ: begin
               if (flush_in) begin
                  state      <= IDLE;
                  mem_a      <= '0;
                  pend_valid <= 1'b0;
               end else if (!rdy_in) begin
                  pend_valid <= 1'b0;
                  issue_idx  <= cap_cnt;
                  mem_a      <= base + {29'b0, cap_cnt};
               end else begin
                  if (pend_valid) begin
                     rbuf    <= merged;
                     cap_cnt <= cap_cnt + 3'd1;
                  end
                  if (pend_valid && last_pend) begin
                     state      <= IDLE;
                     mem_a      <= '0;
                     pend_valid <= 1'b0;
                     if (is_fetch) begin
                        if_done <= 1'b1;
                        if_data <= merged;
                     end else begin
                        ls_done  <= 1'b1;
                        ls_rdata <= merged;
                     end
                  end else if (issue_idx < nbytes) begin
                     pend_valid <= 1'b1;
                     pend_idx   <= issue_idx[1:0];
                     issue_idx  <= next_idx;
                     mem_a      <= (next_idx < nbytes) ? base + {29'b0, next_idx} : '0;
                  end else begin
                     pend_valid <= 1'b0;
                  end
               end
            end

            // Stores ignore flush; I/O stores drop back to IO_WAIT between bytes
            // because io_buffer_full only reflects a write one cycle late.
            WRITE: begin
               if (rdy_in) begin
                  if (last_write) begin
                     state   <= IDLE;
                     mem_wr  <= 1'b0;
                     mem_a   <= '0;
                     ls_done <= 1'b1;
                  end else begin
                     issue_idx <= next_idx;
                     if (base_io) begin
                        state  <= IO_WAIT;
                        mem_wr <= 1'b0;
                        mem_a  <= '0;
                     end else begin
                        mem_a    <= base + {29'b0, next_idx};
                        mem_dout <= pick_byte(wbuf, next_idx[1:0]);
                     end
                  end
               end
            end

            IO_WAIT: begin
               mem_wr <= 1'b0;
               mem_a  <= '0;
               if (rdy_in && !io_buffer_full) begin
                  state    <= WRITE;
                  mem_wr   <= 1'b1;
                  mem_a    <= base + {29'b0, issue_idx};
                  mem_dout <= pick_byte(wbuf, issue_idx[1:0]);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a RAM/UART responder model plus directed scenarios and
// randomized transactions checked against an expected-memory image.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        flush_in;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  ram     [0:2047];
   logic [7:0]  ref_mem [0:2047];
   logic        sync_en = 1'b0;
   int          wr_count = 0;
   int          io_count = 0;
   logic [7:0]  io_last = 8'h00;

   mem_ctrl #(.IO_ADDR_HI(17)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
   );

   always #5 clk_in = ~clk_in;

   // Responder: the bus only reaches RAM/UART while rdy_in is high; otherwise
   // HCI owns it and the read byte returned to the CPU is garbage (0xEE).
   always @(posedge clk_in) begin
      if (sync_en) begin
         for (int i = 0; i < 2048; i++) ram[i] <= ref_mem[i];
      end else if (rdy_in && mem_wr) begin
         if (mem_a[17:16] == 2'b11) begin
            io_count <= io_count + 1;
            io_last  <= mem_dout;
         end else begin
            ram[mem_a[10:0]] <= mem_dout;
            wr_count         <= wr_count + 1;
         end
      end
      mem_din <= rdy_in ? ram[mem_a[10:0]] : 8'hEE;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic is_ls, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (is_ls) begin
         ls_req   = 1'b1;
         ls_we    = we;
         ls_size  = size;
         ls_addr  = addr;
         ls_wdata = wdata;
      end else begin
         if_req  = 1'b1;
         if_addr = addr;
      end
   endtask

   task automatic waitDone(input logic is_ls, input logic rand_rdy, input int limit, output int cycles);
      logic seen;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < limit) begin
         if (rand_rdy) rdy_in = ($urandom_range(0, 3) != 0);
         tick();
         cycles++;
         seen = is_ls ? ls_done : if_done;
      end
      rdy_in = 1'b1;
      if (is_ls) ls_req = 1'b0;
      else if_req = 1'b0;
      checkOutput(is_ls ? "ls_done_seen" : "if_done_seen", 32'(seen), 32'd1);
   endtask

   function automatic logic [31:0] refRead(input logic [31:0] addr, input int n);
      logic [31:0] v = '0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[addr[10:0] + 11'(b)];
      return v;
   endfunction

   function automatic logic [31:0] ramRead(input logic [31:0] addr, input int n);
      logic [31:0] v = '0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = ram[addr[10:0] + 11'(b)];
      return v;
   endfunction

   initial begin
      int          cyc;
      int          wr0;
      int          seen_cnt;
      int          kind;
      int          n;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;

      rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_size = '0;
      ls_addr = '0; ls_wdata = '0;

      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
      ref_mem[11'h100] = 8'h13; ref_mem[11'h101] = 8'h05;
      ref_mem[11'h102] = 8'h00; ref_mem[11'h103] = 8'h00;
      ref_mem[11'h020] = 8'hAB;
      for (int i = 0; i < 4; i++) begin
         ref_mem[11'h000 + 11'(i)] = 8'(8'h11 * (i + 1));
         ref_mem[11'h200 + 11'(i)] = 8'(8'h11 * (i + 1));
         ref_mem[11'h400 + 11'(i)] = 8'h00;
      end
      ref_mem[11'h300] = 8'h00; ref_mem[11'h301] = 8'h00;
      sync_en = 1'b1;
      tick();
      sync_en = 1'b0;
      tick();

      checkOutput("rst_mem_a", mem_a, 32'h0);
      checkOutput("rst_mem_wr", 32'(mem_wr), 32'h0);
      checkOutput("rst_mem_dout", 32'(mem_dout), 32'h0);
      checkOutput("rst_if_done", 32'(if_done), 32'h0);
      checkOutput("rst_ls_done", 32'(ls_done), 32'h0);
      checkOutput("rst_if_data", if_data, 32'h0);
      checkOutput("rst_ls_rdata", ls_rdata, 32'h0);
      rst_n_in = 1'b1;
      tick();

      // Word fetch from 0x100
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("fetch_mem_a", mem_a, 32'h100 + 32'(k));
         checkOutput("fetch_mem_wr", 32'(mem_wr), 32'h0);
      end
      tick();
      checkOutput("fetch_done_c5", 32'(if_done), 32'h0);
      tick();
      checkOutput("fetch_done_c6", 32'(if_done), 32'h1);
      checkOutput("fetch_data", if_data, 32'h00000513);
      if_req = 1'b0;
      tick();
      checkOutput("fetch_done_pulse", 32'(if_done), 32'h0);

      // Simultaneous fetch and byte load: load first
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h20, 32'h0);
      tick();
      checkOutput("sim_ls_addr", mem_a, 32'h20);
      tick();
      tick();
      checkOutput("sim_ls_done", 32'(ls_done), 32'h1);
      checkOutput("sim_ls_rdata", ls_rdata, 32'h000000AB);
      checkOutput("sim_if_not_done", 32'(if_done), 32'h0);
      ls_req = 1'b0;
      tick();
      checkOutput("sim_fetch_start", mem_a, 32'h0);
      waitDone(1'b0, 1'b0, 20, cyc);
      checkOutput("sim_fetch_latency", 32'(cyc), 32'd5);
      checkOutput("sim_fetch_data", if_data, refRead(32'h0, 4));
      tick();

      // I/O store with UART backpressure
      io_buffer_full = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'd0, 32'h30000, 32'h41);
      seen_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen_cnt += int'(mem_wr);
      end
      checkOutput("io_wait_no_wr", 32'(seen_cnt), 32'd0);
      io_buffer_full = 1'b0;
      tick();
      checkOutput("io_wr", 32'(mem_wr), 32'h1);
      checkOutput("io_addr", mem_a, 32'h30000);
      checkOutput("io_dout", 32'(mem_dout), 32'h41);
      tick();
      checkOutput("io_wr_once", 32'(mem_wr), 32'h0);
      checkOutput("io_ls_done", 32'(ls_done), 32'h1);
      ls_req = 1'b0;
      checkOutput("io_count", 32'(io_count), 32'd1);
      checkOutput("io_byte", 32'(io_last), 32'h41);
      tick();

      // Pause during a word load: bytes 1..3 re-issued once rdy_in returns
      applyStimulus(1'b1, 1'b0, 2'd2, 32'h200, 32'h0);
      tick();
      checkOutput("pause_a_c1", mem_a, 32'h200);
      tick();
      checkOutput("pause_a_c2", mem_a, 32'h201);
      tick();
      rdy_in = 1'b0;
      tick();
      tick();
      seen_cnt = int'(ls_done);
      tick();
      rdy_in = 1'b1;
      checkOutput("pause_reissue_c6", mem_a, 32'h201);
      tick();
      checkOutput("pause_reissue_c7", mem_a, 32'h202);
      tick();
      checkOutput("pause_reissue_c8", mem_a, 32'h203);
      tick();
      seen_cnt += int'(ls_done);
      checkOutput("pause_no_early_done", 32'(seen_cnt), 32'd0);
      tick();
      checkOutput("pause_done_c10", 32'(ls_done), 32'h1);
      checkOutput("pause_rdata", ls_rdata, 32'h44332211);
      ls_req = 1'b0;
      tick();

      // Flush during C2 of a fetch
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
      tick();
      tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      if_req = 1'b0;
      checkOutput("flush_park", mem_a, 32'h0);
      seen_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         seen_cnt += int'(if_done);
         tick();
      end
      checkOutput("flush_no_done", 32'(seen_cnt), 32'd0);

      // Flush during a half store: store still completes
      applyStimulus(1'b1, 1'b1, 2'd1, 32'h300, 32'h0000BEEF);
      ref_mem[11'h300] = 8'hEF;
      ref_mem[11'h301] = 8'hBE;
      tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      checkOutput("flush_st_a", mem_a, 32'h301);
      checkOutput("flush_st_dout", 32'(mem_dout), 32'hBE);
      tick();
      checkOutput("flush_st_done", 32'(ls_done), 32'h1);
      ls_req = 1'b0;
      checkOutput("flush_st_ram", ramRead(32'h300, 2), refRead(32'h300, 2));
      tick();

      // Reset during C2 of a word store
      wr0 = wr_count;
      applyStimulus(1'b1, 1'b1, 2'd2, 32'h400, 32'hDDCCBBAA);
      ref_mem[11'h400] = 8'hAA;
      tick();
      tick();
      rst_n_in = 1'b0;
      #1;
      checkOutput("rst_mid_wr", 32'(mem_wr), 32'h0);
      ls_req = 1'b0;
      seen_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen_cnt += int'(ls_done) + int'(mem_wr);
      end
      rst_n_in = 1'b1;
      tick();
      seen_cnt += int'(ls_done) + int'(mem_wr);
      tick();
      seen_cnt += int'(ls_done) + int'(mem_wr);
      checkOutput("rst_mid_quiet", 32'(seen_cnt), 32'd0);
      checkOutput("rst_mid_ram", ramRead(32'h400, 4), refRead(32'h400, 4));
      checkOutput("rst_mid_wr_count", 32'(wr_count - wr0), 32'd1);

      // Randomized transactions with random debug pauses
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         size = 2'($urandom_range(0, 3));
         n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
         if (kind == 0) begin
            addr = 32'($urandom_range(0, 511)) << 2;
            applyStimulus(1'b0, 1'b0, 2'd2, addr, 32'h0);
            waitDone(1'b0, 1'b1, 200, cyc);
            checkOutput("rand_if_data", if_data, refRead(addr, 4));
         end else begin
            addr  = 32'($urandom_range(0, 2047)) & ~(32'(n) - 32'd1);
            wdata = $urandom;
            if (kind == 1) begin
               applyStimulus(1'b1, 1'b0, size, addr, 32'h0);
               waitDone(1'b1, 1'b1, 200, cyc);
               checkOutput("rand_ls_rdata", ls_rdata, refRead(addr, n));
            end else begin
               for (int b = 0; b < n; b++) ref_mem[addr[10:0] + 11'(b)] = wdata[8*b +: 8];
               wr0 = wr_count;
               applyStimulus(1'b1, 1'b1, size, addr, wdata);
               waitDone(1'b1, 1'b1, 200, cyc);
               checkOutput("rand_store_ram", ramRead(addr, n), refRead(addr, n));
               checkOutput("rand_store_wr_count", 32'(wr_count - wr0), 32'(n));
            end
         end
         tick();
      end
      checkOutput("rand_io_untouched", 32'(io_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- CPU-side initiator for the byte-serial system memory bus (mem_a/mem_wr/mem_dout/mem_din, plus rdy_in and io_buffer_full). RAM and HCI are the responders on the far end.
- Accepts word instruction fetches and byte/half/word data loads and stores.
- Serializes each request into little-endian byte accesses under the bus's 1-cycle read latency.
- Honours debug pause (rdy_in) and UART backpressure (io_buffer_full).

Parameters:
- IO_ADDR_HI, 17, bit index; addresses with bits [IO_ADDR_HI:IO_ADDR_HI-1]==2'b11 are I/O (0x30000 and up).

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  high = bus owned by CPU; low = paused, bus owned by HCI
- flush_in  in  1  misprediction flush
- mem_din  in  8  read byte from RAM/IO, valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address, word-aligned
- if_done  out  1  one-cycle pulse
- if_data  out  32  fetched word, valid with if_done
- ls_req  in  1  load/store request, held with all fields stable until ls_done
- ls_we  in  1  1 = store
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- ls_addr  in  32  naturally aligned address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended, valid with ls_done

Behaviour:
- Reset, async on rst_n_in low:
  - State IDLE.
  - mem_a=0, mem_wr=0, mem_dout=0.
  - if_done=0, ls_done=0, if_data=0, ls_rdata=0.
  - All counters 0.
- Reset mid-transfer abandons the transfer. No done pulse is issued and no further bytes are written.
- Bus outputs are registered. In IDLE the bus parks at mem_a=0, mem_wr=0, so an I/O address is never presented idle.
- States: IDLE, READ, WRITE, IO_WAIT.
- Arbitration in IDLE: ls_req has priority over if_req. A request is accepted at edge E0 only if rdy_in=1.
  - Accepted ls_req: next state WRITE if ls_we=1, else READ.
  - Accepted if_req: next state READ with n=4.
- n = number of bytes: 1, 2 or 4 from ls_size; always 4 for fetch.
- Issue index i: byte i is driven as mem_a=base+i during cycle C(i+1), where C(k) is the cycle between edges E(k-1) and E(k).
- READ:
  - An issued byte is marked pending only if rdy_in=1 at the edge closing its address cycle.
  - Pending byte j is captured from mem_din into lane j at the next edge, only if rdy_in=1 there.
  - Done pulse registered at the edge capturing byte n-1.
  - Uninterrupted word read: done visible in C6 (one cycle after the E5 capture edge). Byte read: done visible in C3 (one cycle after the E2 capture edge).
  - Unused upper lanes read 0.
- WRITE:
  - mem_wr=1, mem_dout=ls_wdata[8i+7:8i] during C(i+1).
  - i advances only on edges with rdy_in=1.
  - ls_done visible in C(n+1) for an uninterrupted write.
- rdy_in low at any edge:
  - No capture; all pending marks cleared.
  - Issue index rewinds to the lowest uncaptured byte, so those bytes are re-issued after rdy_in returns.
  - State and captured lanes are held.
- I/O stores:
  - Before driving a write byte whose address is in the I/O range, if io_buffer_full=1, enter IO_WAIT.
  - In IO_WAIT: mem_wr=0, mem_a parked at 0. Retry once io_buffer_full=0.
  - After an I/O write completes, the next I/O write is not issued until at least one IDLE cycle has elapsed (io_buffer_full lags by one cycle).
  - I/O loads use the normal READ path with no extra latency.
- flush_in=1 at an edge:
  - Aborts any fetch or load: return to IDLE, no done pulse.
  - A store in progress completes normally and pulses ls_done.
  - flush_in is ignored in IDLE.
- Simultaneous if_req and ls_req in IDLE: ls is served first. if_req remains pending and is accepted on the IDLE edge after ls_done.
- Back-to-back operation: next request is accepted no earlier than the edge after the done pulse (min one IDLE cycle).

Test Plan:
- Word fetch:
  - RAM[0x100..0x103]=0x13,0x05,0x00,0x00; if_req, if_addr=0x100 accepted at E0.
  - mem_a = 0x100, 0x101, 0x102, 0x103 in C1..C4; if_done in C6 with if_data=0x00000513.
- Simultaneous requests:
  - if_req (0x0) and ls_req byte load from 0x20 (RAM 0xAB) in the same IDLE cycle.
  - ls_done in C3 with ls_rdata=0x000000AB, then the fetch starts the cycle after.
- I/O store with backpressure:
  - ls byte store 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles.
  - mem_wr stays 0 throughout; after full drops, exactly one cycle of mem_wr=1, mem_a=0x30000, mem_dout=0x41, then ls_done.
- Pause mid-read:
  - Word load from 0x200 (RAM 0x44332211); rdy_in low for 3 cycles starting C3.
  - Bytes 1..3 are re-issued after rdy_in rises; ls_rdata=0x44332211; no byte captured while paused.
- Flush:
  - Flush during C2 of a fetch: no if_done, bus parks at 0 next cycle.
  - Flush during a half store 0xBEEF to 0x300: both bytes written, ls_done pulses.
- Reset mid-store: rst_n_in low during C2 of a word store to 0x400 → mem_wr=0 immediately; only RAM[0x400] is modified; no ls_done.
